cache_controller: RTL and testbench
===================================

# cache_controller

Direct-mapped, write-through, no-write-allocate word cache between the pipeline MEM stage and `sram_controller`. It serves hit reads in zero wait cycles and forwards misses and all writes to `sram_controller` through its `r_en_in`/`w_en_in`/`ready_out` handshake. It holds the pipeline with `ready_out` low while an SRAM transaction is outstanding.

## Interface
- `SETS`, 64: number of lines (power of 2, ≥2); one 32-bit word per line.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `r_en_in` input 1: MEM-stage read request, held until `ready_out`.
- `w_en_in` input 1: MEM-stage write request, held until `ready_out`.
- `address_in` input 32: byte address; bits [1:0] ignored.
- `write_data_in` input 32: write data.
- `read_data_out` output 32: read result, valid when `ready_out`=1 with `r_en_in`=1.
- `ready_out` output 1: request complete; low freezes pipeline.
- `sram_r_en_out` output 1: to `sram_controller.r_en_in`.
- `sram_w_en_out` output 1: to `sram_controller.w_en_in`.
- `sram_address_out` output 32: to `sram_controller.address_in`.
- `sram_write_data_out` output 32: to `sram_controller.write_data_in`.
- `sram_read_data_in` input 32: from `sram_controller.read_data_out`.
- `sram_ready_in` input 1: from `sram_controller.ready_out`; one-cycle pulse per transaction.

## Operation
- Address split: index = `address_in[2+log2(SETS)-1:2]`; tag = `address_in[31:2+log2(SETS)]`.
- Per line: valid bit, tag, and 32-bit data. Only the valid bits are reset.
- Hit = valid[index] && tag[index]==tag.
- FSM states are IDLE, MISS, and WRITE.
- IDLE:
  - On `w_en_in`: go to WRITE. A write takes priority if both enables are high.
  - On `r_en_in` with a miss: go to MISS.
  - On `r_en_in` with a hit: stay in IDLE.
- MISS:
  - `sram_r_en_out`=1.
  - On `sram_ready_in`: write the line (valid=1, tag, data=`sram_read_data_in`) and go to IDLE.
- WRITE:
  - `sram_w_en_out`=1.
  - On `sram_ready_in`: if the address hits, update line data with `write_data_in`; a write miss does not allocate. Go to IDLE.
- `sram_address_out` = `address_in` and `sram_write_data_out` = `write_data_in` (pass-through).
- `ready_out` (combinational):
  - 1 in IDLE when there is no request.
  - 1 in IDLE on a read hit.
  - 0 in IDLE when a write or read-miss request is present.
  - In MISS/WRITE, equals `sram_ready_in`.
- `read_data_out`:
  - Cache data on an IDLE hit.
  - `sram_read_data_in` in MISS when `sram_ready_in`=1.
  - Otherwise 0.

## Timing
- Reset values: state IDLE; all valid=0; `sram_r_en_out`=`sram_w_en_out`=0. `ready_out`=1 and `read_data_out`=0 while no request is present.
- Read hit: 0 wait cycles; `ready_out` is high in the same cycle as `r_en_in`.
- Read miss:
  - Cycle 0 is IDLE (`ready_out`=0).
  - SRAM enable is high from cycle 1 until the cycle of `sram_ready_in`, inclusive.
  - Data and `ready_out` appear in the `sram_ready_in` cycle; the line is written at that edge.
- Write: same timing as a read miss, using `sram_w_en_out`.
- SRAM enables are asserted only in MISS/WRITE. This guarantees at least one low cycle between back-to-back SRAM transactions, which rearms `sram_controller`.
- A request changing while in MISS/WRITE is a protocol violation by the requester; behaviour is undefined.
- `sram_ready_in` while in IDLE is ignored.
- Reset asserted mid-MISS/WRITE: enables drop immediately (asynchronously), the FSM goes to IDLE, and all lines are invalidated. No partial line fill occurs.

## Configuration
- `CACHE_STATS_EN` defined: adds `hit_count_out` output [15:0] and `miss_count_out` output [15:0].
  - Each counter saturates at 16'hFFFF; both reset to 0.
  - Hit counts +1 per completed read hit.
  - Miss counts +1 per MISS entry.
  - Writes are not counted.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Cold read: after reset, read `0x0000_0400`; SRAM model returns `0xDEADBEEF` after 6 cycles.
  - `sram_r_en_out` rises 1 cycle after the request.
  - `ready_out` and `read_data_out`=`0xDEADBEEF` appear with `sram_ready_in`.
  - `miss_count_out`=1.
- Hit: re-read `0x0000_0400`.
  - `ready_out`=1 in the same cycle, data=`0xDEADBEEF`.
  - No SRAM enable asserted.
  - `hit_count_out`=1.
- Write hit: write `0x3344_1122` to `0x0000_0400`.
  - `sram_w_en_out` is high with `sram_write_data_out`=`0x3344_1122` until `sram_ready_in`.
  - A following read hits with `0x3344_1122`.
- Conflict eviction: read `0x0000_0500` (index 0, different tag).
  - This read misses and fills.
  - A subsequent read of `0x0000_0400` misses again.
- Write miss: write `0x0000_0800`, then read `0x0000_0800`.
  - The write completes via SRAM without allocating.
  - The read misses.
- Reset mid-miss: pull `rst` low during MISS.
  - `sram_r_en_out`=0 immediately.
  - After release, reading `0x0000_0500` misses.

Source files
------------

// File: rtl/cache_controller.sv
// Direct-mapped write-through, no-write-allocate word cache in front of sram_controller.
// Define CACHE_STATS_EN to add saturating hit/miss counters.
module cache_controller #(
  parameter int SETS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_en_in,
  input  logic        w_en_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  output logic [31:0] read_data_out,
  output logic        ready_out,
  output logic        sram_r_en_out,
  output logic        sram_w_en_out,
  output logic [31:0] sram_address_out,
  output logic [31:0] sram_write_data_out,
  input  logic [31:0] sram_read_data_in,
  input  logic        sram_ready_in
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count_out,
  output logic [15:0] miss_count_out
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    WRITE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_mem  [SETS];
  logic [31:0]     data_mem [SETS];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;
  logic          fill;
  logic          wr_upd;
  logic          unused_addr;

  assign idx         = address_in[IW+1:2];
  assign tag         = address_in[31:IW+2];
  assign unused_addr = ^address_in[1:0];
  assign hit         = valid[idx] && (tag_mem[idx] == tag);
  assign fill        = (state == MISS) && sram_ready_in;
  assign wr_upd      = (state == WRITE) && sram_ready_in && hit;

  assign sram_address_out    = address_in;
  assign sram_write_data_out = write_data_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Only the valid bits need a reset; tags and data are gated by them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (fill) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= sram_read_data_in;
    end else if (wr_upd) begin
      data_mem[idx] <= write_data_in;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          w_en_in:           state_nx = WRITE;
          r_en_in && !hit:   state_nx = MISS;
          default:           state_nx = IDLE;
        endcase
      end
      MISS, WRITE: begin
        if (sram_ready_in) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready_out     = 1'b0;
    read_data_out = 32'h0;
    sram_r_en_out = 1'b0;
    sram_w_en_out = 1'b0;
    unique case (state)
      IDLE: begin
        ready_out = !w_en_in && !(r_en_in && !hit);
        if (r_en_in && !w_en_in && hit) read_data_out = data_mem[idx];
      end
      MISS: begin
        sram_r_en_out = 1'b1;
        ready_out     = sram_ready_in;
        if (sram_ready_in) read_data_out = sram_read_data_in;
      end
      WRITE: begin
        sram_w_en_out = 1'b1;
        ready_out     = sram_ready_in;
      end
      default: ready_out = 1'b0;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic hit_evt;
  logic miss_evt;

  assign hit_evt  = (state == IDLE) && r_en_in && !w_en_in && hit;
  assign miss_evt = (state == IDLE) && r_en_in && !w_en_in && !hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_out  <= 16'h0;
      miss_count_out <= 16'h0;
    end else begin
      if (hit_evt && hit_count_out != 16'hFFFF)
        hit_count_out <= hit_count_out + 16'h1;
      if (miss_evt && miss_count_out != 16'hFFFF)
        miss_count_out <= miss_count_out + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a transaction table plus reset and
// idle-pulse sequences, with the bench acting as sram_controller.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en_in;
  logic        w_en_in;
  logic [31:0] address_in;
  logic [31:0] write_data_in;
  logic [31:0] read_data_out;
  logic        ready_out;
  logic        sram_r_en_out;
  logic        sram_w_en_out;
  logic [31:0] sram_address_out;
  logic [31:0] sram_write_data_out;
  logic [31:0] sram_read_data_in;
  logic        sram_ready_in;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_out;
  logic [15:0] miss_count_out;
`endif

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  cache_controller #(.SETS(64)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .r_en_in             (r_en_in),
    .w_en_in             (w_en_in),
    .address_in          (address_in),
    .write_data_in       (write_data_in),
    .read_data_out       (read_data_out),
    .ready_out           (ready_out),
    .sram_r_en_out       (sram_r_en_out),
    .sram_w_en_out       (sram_w_en_out),
    .sram_address_out    (sram_address_out),
    .sram_write_data_out (sram_write_data_out),
    .sram_read_data_in   (sram_read_data_in),
    .sram_ready_in       (sram_ready_in)
`ifdef CACHE_STATS_EN
    ,
    .hit_count_out       (hit_count_out),
    .miss_count_out      (miss_count_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          lat;
    logic        miss;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " idle ready"}, {31'h0, ready_out}, 32'h1);
    chk({nm, " idle rdata"}, read_data_out, 32'h0);
    chk({nm, " idle sram_r"}, {31'h0, sram_r_en_out}, 32'h0);
    chk({nm, " idle sram_w"}, {31'h0, sram_w_en_out}, 32'h0);
`ifdef CACHE_STATS_EN
    chk({nm, " hit_count"}, {16'h0, hit_count_out}, exp_hits);
    chk({nm, " miss_count"}, {16'h0, miss_count_out}, exp_misses);
`endif
  endtask

  task automatic xact(input vec_t v, input string nm);
    @(negedge clk);
    r_en_in           = v.rd;
    w_en_in           = v.wr;
    address_in        = v.addr;
    write_data_in     = v.wdata;
    sram_ready_in     = 1'b0;
    sram_read_data_in = ~v.sdata;
    #1;
    chk({nm, " addr pass"}, sram_address_out, v.addr);
    chk({nm, " wdata pass"}, sram_write_data_out, v.wdata);
    if (!v.miss) begin
      chk({nm, " hit ready"}, {31'h0, ready_out}, 32'h1);
      chk({nm, " hit rdata"}, read_data_out, v.exp);
      chk({nm, " hit no sram"}, {30'h0, sram_r_en_out, sram_w_en_out}, 32'h0);
      if (v.rd && !v.wr) exp_hits++;
    end else begin
      chk({nm, " c0 ready"}, {31'h0, ready_out}, 32'h0);
      chk({nm, " c0 sram"}, {30'h0, sram_r_en_out, sram_w_en_out}, 32'h0);
      if (!v.wr) chk({nm, " c0 rdata"}, read_data_out, 32'h0);
      if (v.rd && !v.wr) exp_misses++;
      for (int c = 1; c <= v.lat; c++) begin
        @(negedge clk);
        if (c == v.lat) begin
          sram_ready_in     = 1'b1;
          sram_read_data_in = v.sdata;
        end
        #1;
        chk({nm, " sram_r"}, {31'h0, sram_r_en_out}, {31'h0, !v.wr});
        chk({nm, " sram_w"}, {31'h0, sram_w_en_out}, {31'h0, v.wr});
        chk({nm, " ready"}, {31'h0, ready_out}, {31'h0, c == v.lat});
        chk({nm, " rdata"}, read_data_out,
            (c == v.lat && !v.wr) ? v.sdata : 32'h0);
      end
    end
    @(negedge clk);
    r_en_in           = 1'b0;
    w_en_in           = 1'b0;
    sram_ready_in     = 1'b0;
    sram_read_data_in = 32'hCAFE_0000;
    #1;
    chk_idle(nm);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 6, 1'b1, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h400, 32'h33441122, 32'h0, 3, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 0, 1'b0, 32'h33441122};
    tbl[4]  = '{1'b1, 1'b0, 32'h500, 32'h0, 32'h55550500, 2, 1'b1, 32'h55550500};
    tbl[5]  = '{1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 0, 1'b0, 32'h55550500};
    tbl[6]  = '{1'b1, 1'b0, 32'h400, 32'h0, 32'h33441122, 1, 1'b1, 32'h33441122};
    tbl[7]  = '{1'b0, 1'b1, 32'h800, 32'hAAAA0800, 32'h0, 2, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 0, 1'b0, 32'h33441122};
    tbl[9]  = '{1'b1, 1'b0, 32'h800, 32'h0, 32'hAAAA0800, 4, 1'b1, 32'hAAAA0800};
    tbl[10] = '{1'b1, 1'b0, 32'h404, 32'h0, 32'h11110404, 1, 1'b1, 32'h11110404};
    tbl[11] = '{1'b1, 1'b0, 32'h800, 32'h0, 32'h0, 0, 1'b0, 32'hAAAA0800};
    tbl[12] = '{1'b1, 1'b0, 32'h404, 32'h0, 32'h0, 0, 1'b0, 32'h11110404};
    tbl[13] = '{1'b1, 1'b1, 32'h404, 32'h77770404, 32'h0, 2, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 32'h404, 32'h0, 32'h0, 0, 1'b0, 32'h77770404};
    tbl[15] = '{1'b1, 1'b0, 32'h3FC, 32'h0, 32'h0BADF00D, 3, 1'b1, 32'h0BADF00D};
    tbl[16] = '{1'b1, 1'b0, 32'h3FC, 32'h0, 32'h0, 0, 1'b0, 32'h0BADF00D};
    tbl[17] = '{1'b1, 1'b0, 32'h3FF, 32'h0, 32'h0, 0, 1'b0, 32'h0BADF00D};

    rst               = 1'b0;
    r_en_in           = 1'b0;
    w_en_in           = 1'b0;
    address_in        = 32'h0;
    write_data_in     = 32'h0;
    sram_read_data_in = 32'h0;
    sram_ready_in     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      xact(tbl[i], $sformatf("vec%0d", i));
    end

    // sram_ready_in pulse while idle must not move the FSM
    @(negedge clk);
    sram_ready_in     = 1'b1;
    sram_read_data_in = 32'h12345678;
    #1;
    chk_idle("stray ready");
    @(negedge clk);
    sram_ready_in = 1'b0;
    #1;
    chk_idle("after stray");

    // reset in the middle of a read miss
    @(negedge clk);
    r_en_in    = 1'b1;
    address_in = 32'h500;
    #1;
    chk("rstmiss c0 ready", {31'h0, ready_out}, 32'h0);
    @(negedge clk);
    #1;
    chk("rstmiss sram_r on", {31'h0, sram_r_en_out}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmiss sram_r off", {31'h0, sram_r_en_out}, 32'h0);
    chk("rstmiss ready", {31'h0, ready_out}, 32'h0);
    @(negedge clk);
    r_en_in    = 1'b0;
    rst        = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
    #1;
    chk_idle("rstmiss release");

    xact('{1'b1, 1'b0, 32'h404, 32'h0, 32'h77770404, 2, 1'b1, 32'h77770404},
         "post rst 404");
    xact('{1'b1, 1'b0, 32'h500, 32'h0, 32'h55550500, 3, 1'b1, 32'h55550500},
         "post rst 500");
    xact('{1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 0, 1'b0, 32'h55550500},
         "post rst hit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
